// File: rtl/loop_nest_counter.sv
// Nested-loop index generator: LEVELS chained counters (level 0 innermost) with programmable bounds.
// Optional value skipping per level is enabled by defining LNC_SKIP_EN.
module loop_nest_counter #(
  parameter int LEVELS   = 3,
  parameter int WIDTH    = 3,
  parameter int ONE_SHOT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    load,
  input  logic [LEVELS*WIDTH-1:0] bound_in,
`ifdef LNC_SKIP_EN
  input  logic [LEVELS-1:0]       skip_mask,
  input  logic [LEVELS*WIDTH-1:0] skip_val,
`endif
  output logic [LEVELS*WIDTH-1:0] count,
  output logic [LEVELS*WIDTH-1:0] prev_count,
  output logic [LEVELS-1:0]       level_wrap,
  output logic                    at_max,
  output logic                    done
);

  localparam bit HOLD = (ONE_SHOT != 0);

  logic [LEVELS*WIDTH-1:0] bound_q;
  logic [LEVELS*WIDTH-1:0] count_nxt;
  logic [LEVELS-1:0]       wrap_nxt;
  logic [LEVELS-1:0]       at_bound;
  logic [WIDTH-1:0]        inc;
  logic                    carry;

  // Ripple the carry from level 0 upward; a level at its bound passes it on.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = '0;
    at_bound  = '0;
    inc       = '0;
    carry     = 1'b1;
    for (int i = 0; i < LEVELS; i++) begin
      at_bound[i] = (count[i*WIDTH +: WIDTH] == bound_q[i*WIDTH +: WIDTH]);
      inc = count[i*WIDTH +: WIDTH] + WIDTH'(1);
`ifdef LNC_SKIP_EN
      if (skip_mask[i] && (skip_val[i*WIDTH +: WIDTH] != '0) &&
          (skip_val[i*WIDTH +: WIDTH] < bound_q[i*WIDTH +: WIDTH]) &&
          (inc == skip_val[i*WIDTH +: WIDTH]))
        inc = inc + WIDTH'(1);
`endif
      if (carry) begin
        if (at_bound[i]) begin
          count_nxt[i*WIDTH +: WIDTH] = '0;
          wrap_nxt[i] = 1'b1;
        end else begin
          count_nxt[i*WIDTH +: WIDTH] = inc;
        end
      end
      carry = carry & at_bound[i];
    end
  end

  assign at_max = &at_bound;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bound_q    <= '1;
      count      <= '0;
      prev_count <= '0;
      level_wrap <= '0;
      done       <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      prev_count <= '0;
      level_wrap <= '0;
      done       <= 1'b0;
    end else if (load) begin
      bound_q    <= bound_in;
      count      <= '0;
      prev_count <= '0;
      level_wrap <= '0;
      done       <= 1'b0;
    end else if (en && !(HOLD && done)) begin
      prev_count <= count;
      if (HOLD && at_max) begin
        // one-shot terminal: freeze at bounds and latch done
        level_wrap <= '0;
        done       <= 1'b1;
      end else begin
        count      <= count_nxt;
        level_wrap <= wrap_nxt;
        done       <= at_max;
      end
    end else begin
      level_wrap <= '0;
      if (!HOLD) done <= 1'b0;
    end
  end

endmodule
